id_ex_latch: RTL and testbench
==============================

Name: id_ex_latch

Overview:
- ID/EX pipeline register of the 5-stage MIPS datapath; captures decode-stage operands, the sign-extended immediate, register specifiers and control bundles on each rising clock.
- Feeds the EX stage directly:
  - ex_alusrc is the select of the ALU-B operand mux.
  - ex_signext drives that mux's 1-input.
  - ex_rdata2 drives its 0-input.
- Supports stall (hold contents) and flush (insert bubble), with a valid bit per entry.

Parameters:
- DATA_W, 32, width of npc, rdata1, rdata2 and the extended immediate.
- REG_ADDR_W, 5, width of the rs/rt/rd register specifiers.
- IMM_W, 16, width of the raw immediate field; must satisfy IMM_W < DATA_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold all registered contents this cycle
- flush  in  1  replace the entry with a bubble this cycle
- id_valid  in  1  decode stage presents a real instruction
- id_ctlwb  in  2  {regwrite, memtoreg}
- id_ctlm  in  3  {branch, memread, memwrite}
- id_ctlex  in  4  {regdst, aluop[1:0], alusrc}
- id_npc  in  DATA_W  PC+4 of the instruction
- id_rdata1  in  DATA_W  register file read port 1
- id_rdata2  in  DATA_W  register file read port 2
- id_imm  in  IMM_W  instr[15:0]
- id_rs, id_rt, id_rd  in  REG_ADDR_W each  instr[25:21], [20:16], [15:11]
- ex_valid  out  1  registered valid
- ex_ctlwb  out  2  registered WB control
- ex_ctlm  out  3  registered MEM control
- ex_regdst  out  1  registered
- ex_aluop  out  2  registered
- ex_alusrc  out  1  registered; ALU-B mux select
- ex_npc, ex_rdata1, ex_rdata2  out  DATA_W each  registered
- ex_signext  out  DATA_W  registered sign-extended immediate
- ex_rs, ex_rt, ex_rd  out  REG_ADDR_W each  registered
- ex_stall_cnt  out  32  stall cycle count (optional feature)
- ex_bubble_cnt  out  32  bubbles inserted (optional feature)

Behaviour:
- Reset: rst_n low asynchronously clears every output to 0, including the counters. Release is sampled on the next clk edge. Reset asserted mid-stall or mid-flush overrides both immediately.
- Latency: inputs appear on outputs one clk after capture. No combinational path from input to output.
- Per-edge action, priority flush > stall > load:
  - FLUSH (flush=1, regardless of stall): ex_valid=0; all control outputs (ctlwb, ctlm, regdst, aluop, alusrc) = 0; data and specifier outputs = 0.
  - HOLD (flush=0, stall=1): every output keeps its value, including ex_valid.
  - LOAD (flush=0, stall=0): capture all id_* fields. If id_valid=0, control outputs are forced to 0 and ex_valid=0, but data fields are still captured.
- Sign extension: ex_signext = {(DATA_W-IMM_W) copies of id_imm[IMM_W-1], id_imm}, computed at capture.
- A bubble (ex_valid=0) must always carry zero regwrite/memwrite/memread/branch so downstream stages commit nothing.
- Internally there is no state beyond the pipeline registers and the optional counters. The three actions above are the complete transition set.

Optional Feature:
- Macro ID_EX_PERF_EN.
- Defined:
  - ex_stall_cnt increments on every edge where stall=1 and flush=0.
  - ex_bubble_cnt increments on every edge that produces ex_valid=0, from either flush or LOAD with id_valid=0.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized. All other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 between edges with nonzero inputs -> all outputs 0 immediately, with no clk edge needed.
- Load: id_valid=1, id_ctlex=4'b0001, id_rdata2=32'h0000_0005, id_imm=16'hFFFC -> next edge ex_alusrc=1, ex_signext=32'hFFFF_FFFC, ex_rdata2=32'h5, ex_valid=1.
- Positive immediate: id_imm=16'h7FFF -> ex_signext=32'h0000_7FFF.
- Stall: load id_rdata1=32'hDEAD_BEEF, then stall=1 for 3 edges while inputs change -> outputs stay at the loaded values. With ID_EX_PERF_EN, ex_stall_cnt=3.
- Flush priority: flush=1 and stall=1 on the same edge with ctlwb=2'b11 held in the latch -> ex_ctlwb=0, ex_valid=0, ex_signext=0. With ID_EX_PERF_EN, ex_bubble_cnt increments by 1.
- Invalid load: id_valid=0, id_ctlm=3'b010, id_npc=32'h40 -> ex_ctlm=0, ex_valid=0, ex_npc=32'h40.

Source files
------------

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register: decode operands, sign-extended immediate, specifiers and control bundles.
// Optional stall/bubble performance counters are enabled by defining ID_EX_PERF_EN.
module id_ex_latch #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [1:0]            id_ctlwb,
    input  logic [2:0]            id_ctlm,
    input  logic [3:0]            id_ctlex,
    input  logic [DATA_W-1:0]     id_npc,
    input  logic [DATA_W-1:0]     id_rdata1,
    input  logic [DATA_W-1:0]     id_rdata2,
    input  logic [IMM_W-1:0]      id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    output logic                  ex_valid,
    output logic [1:0]            ex_ctlwb,
    output logic [2:0]            ex_ctlm,
    output logic                  ex_regdst,
    output logic [1:0]            ex_aluop,
    output logic                  ex_alusrc,
    output logic [DATA_W-1:0]     ex_npc,
    output logic [DATA_W-1:0]     ex_rdata1,
    output logic [DATA_W-1:0]     ex_rdata2,
    output logic [DATA_W-1:0]     ex_signext,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [31:0]           ex_stall_cnt,
    output logic [31:0]           ex_bubble_cnt
);

    logic [DATA_W-1:0] signext_d;

    assign signext_d = {{(DATA_W-IMM_W){id_imm[IMM_W-1]}}, id_imm};

    // Control fields are gated by id_valid so a bubble never carries a commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_ctlwb   <= '0;
            ex_ctlm    <= '0;
            ex_regdst  <= 1'b0;
            ex_aluop   <= '0;
            ex_alusrc  <= 1'b0;
            ex_npc     <= '0;
            ex_rdata1  <= '0;
            ex_rdata2  <= '0;
            ex_signext <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_ctlwb   <= '0;
            ex_ctlm    <= '0;
            ex_regdst  <= 1'b0;
            ex_aluop   <= '0;
            ex_alusrc  <= 1'b0;
            ex_npc     <= '0;
            ex_rdata1  <= '0;
            ex_rdata2  <= '0;
            ex_signext <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
        end else if (!stall) begin
            ex_valid   <= id_valid;
            ex_ctlwb   <= id_valid ? id_ctlwb : 2'b00;
            ex_ctlm    <= id_valid ? id_ctlm : 3'b000;
            ex_regdst  <= id_valid & id_ctlex[3];
            ex_aluop   <= id_valid ? id_ctlex[2:1] : 2'b00;
            ex_alusrc  <= id_valid & id_ctlex[0];
            ex_npc     <= id_npc;
            ex_rdata1  <= id_rdata1;
            ex_rdata2  <= id_rdata2;
            ex_signext <= signext_d;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
        end
    end

`ifdef ID_EX_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;
    logic        stall_evt;
    logic        bubble_evt;

    assign stall_evt  = stall & ~flush;
    assign bubble_evt = flush | (~stall & ~id_valid);

    // Saturating counters; a held bubble is not counted again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bubble_evt && (bubble_cnt_q != 32'hFFFF_FFFF))
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign ex_stall_cnt  = stall_cnt_q;
    assign ex_bubble_cnt = bubble_cnt_q;
`else
    assign ex_stall_cnt  = 32'd0;
    assign ex_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_latch.sv
// Table-driven bench for id_ex_latch plus hand-written asynchronous reset sequences.
module tb_id_ex_latch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [1:0]  id_ctlwb;
    logic [2:0]  id_ctlm;
    logic [3:0]  id_ctlex;
    logic [31:0] id_npc;
    logic [31:0] id_rdata1;
    logic [31:0] id_rdata2;
    logic [15:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        ex_valid;
    logic [1:0]  ex_ctlwb;
    logic [2:0]  ex_ctlm;
    logic        ex_regdst;
    logic [1:0]  ex_aluop;
    logic        ex_alusrc;
    logic [31:0] ex_npc;
    logic [31:0] ex_rdata1;
    logic [31:0] ex_rdata2;
    logic [31:0] ex_signext;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [31:0] ex_stall_cnt;
    logic [31:0] ex_bubble_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall, flush, valid;
        logic [1:0]  ctlwb;
        logic [2:0]  ctlm;
        logic [3:0]  ctlex;
        logic [31:0] npc, rdata1, rdata2;
        logic [15:0] imm;
        logic [4:0]  rs, rt, rd;
        logic        e_valid;
        logic [1:0]  e_ctlwb;
        logic [2:0]  e_ctlm;
        logic        e_regdst;
        logic [1:0]  e_aluop;
        logic        e_alusrc;
        logic [31:0] e_npc, e_rdata1, e_rdata2, e_signext;
        logic [4:0]  e_rs, e_rt, e_rd;
        logic [31:0] e_scnt, e_bcnt;
    } vec_t;

    vec_t vecs[11];

    id_ex_latch dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_ctlwb(id_ctlwb), .id_ctlm(id_ctlm), .id_ctlex(id_ctlex), .id_npc(id_npc),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_valid(ex_valid), .ex_ctlwb(ex_ctlwb), .ex_ctlm(ex_ctlm), .ex_regdst(ex_regdst),
        .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_npc(ex_npc), .ex_rdata1(ex_rdata1),
        .ex_rdata2(ex_rdata2), .ex_signext(ex_signext), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_stall_cnt(ex_stall_cnt), .ex_bubble_cnt(ex_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkField({tag, " valid"},   {31'd0, ex_valid},  {31'd0, v.e_valid});
        checkField({tag, " ctlwb"},   {30'd0, ex_ctlwb},  {30'd0, v.e_ctlwb});
        checkField({tag, " ctlm"},    {29'd0, ex_ctlm},   {29'd0, v.e_ctlm});
        checkField({tag, " regdst"},  {31'd0, ex_regdst}, {31'd0, v.e_regdst});
        checkField({tag, " aluop"},   {30'd0, ex_aluop},  {30'd0, v.e_aluop});
        checkField({tag, " alusrc"},  {31'd0, ex_alusrc}, {31'd0, v.e_alusrc});
        checkField({tag, " npc"},     ex_npc,     v.e_npc);
        checkField({tag, " rdata1"},  ex_rdata1,  v.e_rdata1);
        checkField({tag, " rdata2"},  ex_rdata2,  v.e_rdata2);
        checkField({tag, " signext"}, ex_signext, v.e_signext);
        checkField({tag, " rs"},      {27'd0, ex_rs}, {27'd0, v.e_rs});
        checkField({tag, " rt"},      {27'd0, ex_rt}, {27'd0, v.e_rt});
        checkField({tag, " rd"},      {27'd0, ex_rd}, {27'd0, v.e_rd});
`ifdef ID_EX_PERF_EN
        checkField({tag, " stall_cnt"},  ex_stall_cnt,  v.e_scnt);
        checkField({tag, " bubble_cnt"}, ex_bubble_cnt, v.e_bcnt);
`else
        checkField({tag, " stall_cnt"},  ex_stall_cnt,  32'd0);
        checkField({tag, " bubble_cnt"}, ex_bubble_cnt, 32'd0);
`endif
    endtask

    task automatic driveInputs(input vec_t v);
        stall     = v.stall;
        flush     = v.flush;
        id_valid  = v.valid;
        id_ctlwb  = v.ctlwb;
        id_ctlm   = v.ctlm;
        id_ctlex  = v.ctlex;
        id_npc    = v.npc;
        id_rdata1 = v.rdata1;
        id_rdata2 = v.rdata2;
        id_imm    = v.imm;
        id_rs     = v.rs;
        id_rt     = v.rt;
        id_rd     = v.rd;
    endtask

    // Drive between edges, let one rising edge capture, then sample just after it.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        driveInputs(v);
        @(posedge clk);
        #1;
    endtask

    vec_t zeroVec;
    vec_t busyVec;

    initial begin
        // stall flush valid ctlwb ctlm ctlex npc rdata1 rdata2 imm rs rt rd |
        // e_valid e_ctlwb e_ctlm e_regdst e_aluop e_alusrc e_npc e_rdata1 e_rdata2 e_signext e_rs e_rt e_rd e_scnt e_bcnt
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 4'b0001, 32'h4, 32'h1, 32'h5, 16'hFFFC, 5'd1, 5'd2, 5'd3,
                     1'b1, 2'b10, 3'b000, 1'b0, 2'b00, 1'b1, 32'h4, 32'h1, 32'h5, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'b11, 3'b010, 4'b1100, 32'h8, 32'hDEAD_BEEF, 32'h1234, 16'h7FFF, 5'd4, 5'd5, 5'd6,
                     1'b1, 2'b11, 3'b010, 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h1234, 32'h0000_7FFF, 5'd4, 5'd5, 5'd6, 32'd0, 32'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'b00, 3'b111, 4'b1111, 32'hC, 32'h1111_1111, 32'h2222_2222, 16'h8000, 5'd7, 5'd8, 5'd9,
                     1'b1, 2'b11, 3'b010, 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h1234, 32'h0000_7FFF, 5'd4, 5'd5, 5'd6, 32'd1, 32'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'b01, 3'b101, 4'b0011, 32'h10, 32'h3333_3333, 32'h4444_4444, 16'h0001, 5'd10, 5'd11, 5'd12,
                     1'b1, 2'b11, 3'b010, 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h1234, 32'h0000_7FFF, 5'd4, 5'd5, 5'd6, 32'd2, 32'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'b10, 3'b001, 4'b0101, 32'h14, 32'h5555_5555, 32'h6666_6666, 16'h1234, 5'd13, 5'd14, 5'd15,
                     1'b1, 2'b11, 3'b010, 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h1234, 32'h0000_7FFF, 5'd4, 5'd5, 5'd6, 32'd3, 32'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 2'b11, 3'b111, 4'b1111, 32'h18, 32'h7777_7777, 32'h8888_8888, 16'hFFFF, 5'd16, 5'd17, 5'd18,
                     1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'd3, 32'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'b11, 3'b010, 4'b1111, 32'h40, 32'hA5, 32'h5A, 16'h8001, 5'd10, 5'd11, 5'd12,
                     1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'h40, 32'hA5, 32'h5A, 32'hFFFF_8001, 5'd10, 5'd11, 5'd12, 32'd3, 32'd2};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'b11, 3'b111, 4'b1111, 32'h99, 32'h99, 32'h99, 16'h0099, 5'd1, 5'd1, 5'd1,
                     1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'h40, 32'hA5, 32'h5A, 32'hFFFF_8001, 5'd10, 5'd11, 5'd12, 32'd4, 32'd2};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'b01, 3'b100, 4'b0110, 32'h44, 32'h8000_0000, 32'hFFFF_FFFF, 16'h0000, 5'd31, 5'd0, 5'd17,
                     1'b1, 2'b01, 3'b100, 1'b0, 2'b11, 1'b0, 32'h44, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 5'd31, 5'd0, 5'd17, 32'd4, 32'd2};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 2'b11, 3'b111, 4'b1111, 32'h48, 32'h1, 32'h2, 16'h0003, 5'd4, 5'd5, 5'd6,
                     1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'd4, 32'd3};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 2'b10, 3'b001, 4'b1000, 32'h100, 32'h7, 32'h9, 16'h8000, 5'd2, 5'd3, 5'd4,
                     1'b1, 2'b10, 3'b001, 1'b1, 2'b00, 1'b0, 32'h100, 32'h7, 32'h9, 32'hFFFF_8000, 5'd2, 5'd3, 5'd4, 32'd4, 32'd3};

        zeroVec = '{1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0,
                    1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0};
        busyVec = '{1'b1, 1'b0, 1'b1, 2'b11, 3'b111, 4'b1111, 32'hABCD, 32'h1234_5678, 32'h9ABC_DEF0, 16'h8123, 5'd9, 5'd10, 5'd11,
                    1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0};

        // Power-on reset with nonzero inputs present.
        rst_n = 1'b0;
        driveInputs(busyVec);
        #2;
        checkOutput("por", zeroVec);
        @(posedge clk);
        #1;
        checkOutput("por_edge", zeroVec);
        @(negedge clk);
        driveInputs(zeroVec);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset asserted between edges while a stall is pending must clear everything at once.
        driveInputs(busyVec);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst", zeroVec);
        @(posedge clk);
        #1;
        checkOutput("rst_over_stall", zeroVec);

        // Reset held across an edge that requests flush must still read all zero.
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_over_flush", zeroVec);

        // Release, then a plain load from a freshly cleared latch.
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(vecs[0]);
        checkOutput("post_rst_load", vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
